// File: rtl/pwr_seq_if.sv
// Native memory bus slice seen by the power-down sequencer.
// master drives the request, slave returns select/ready/read data.
interface pwr_seq_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        pwr_sel;
  logic        pwr_ready;
  logic [31:0] pwr_rdata;

  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  input  pwr_sel, pwr_ready, pwr_rdata);
  modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  output pwr_sel, pwr_ready, pwr_rdata);
endinterface

// File: rtl/pwr_seq.sv
// Ordered power-down: halt CPU, wait for idle (bounded), count hold-off,
// then raise a sticky poweroff. CTRL at ADDR, DELAY at ADDR+4.
module pwr_seq #(
  parameter logic [31:0] ADDR          = 32'hffff_fff0,
  parameter logic [15:0] HALT_TIMEOUT  = 16'd255,
  parameter logic [15:0] DEFAULT_DELAY = 16'd16
) (
  input  logic       clk,
  input  logic       reset,
  pwr_seq_if.slave   bus,
  input  logic       cpu_idle,
  output logic       cpu_halt,
  output logic       poweroff
);

  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, COUNT = 2'd2, OFF = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] delay_q, delay_d;
  logic        tflag_q, tflag_d;
  logic        halt_d, off_d;

  logic sel_ctrl, sel_dly, wr;
  assign sel_ctrl = bus.mem_valid && (bus.mem_addr == ADDR);
  assign sel_dly  = bus.mem_valid && (bus.mem_addr == ADDR + 32'd4);
  assign wr       = |bus.mem_wstrb;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      delay_q  <= DEFAULT_DELAY;
      tflag_q  <= 1'b0;
      cpu_halt <= 1'b0;
      poweroff <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
      tflag_q  <= tflag_d;
      cpu_halt <= halt_d;
      poweroff <= off_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    tflag_d = tflag_q;
    unique case (state_q)
      RUN: begin
        if (sel_dly && wr) begin
          if (bus.mem_wstrb[0]) delay_d[7:0]  = bus.mem_wdata[7:0];
          if (bus.mem_wstrb[1]) delay_d[15:8] = bus.mem_wdata[15:8];
        end
        if (sel_ctrl && bus.mem_wstrb[0] && (bus.mem_wdata[7:0] != 8'd0)) begin
          state_d = HALT;
          cnt_d   = HALT_TIMEOUT;
        end
      end
      HALT: begin
        // idle wins over a timeout landing on the same cycle
        if (cpu_idle) begin
          state_d = COUNT;
          cnt_d   = delay_q;
        end else if (cnt_q == 16'd0) begin
          tflag_d = 1'b1;
          state_d = COUNT;
          cnt_d   = delay_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      COUNT: begin
        if (cnt_q == 16'd0) state_d = OFF;
        else                cnt_d   = cnt_q - 16'd1;
      end
      OFF: ;
      default: ;
    endcase
  end

  // Registered outputs follow the next state so they line up with it.
  always_comb begin
    halt_d        = (state_d != RUN);
    off_d         = (state_d == OFF);
    bus.pwr_sel   = sel_ctrl || sel_dly;
    bus.pwr_ready = 1'b1;
    if (sel_ctrl)     bus.pwr_rdata = {29'd0, tflag_q, state_q};
    else if (sel_dly) bus.pwr_rdata = {16'd0, delay_q};
    else              bus.pwr_rdata = 32'd0;
  end

endmodule

// File: tb/tb_pwr_seq.sv
// Bench for pwr_seq: constant vector table, directed corner sequences, and
// random traffic against a timestamp-based reference model.
module tb_pwr_seq;
  localparam logic [31:0] A  = 32'hffff_fff0;
  localparam logic [31:0] D  = A + 32'd4;
  localparam logic [31:0] O  = 32'h0000_1000;
  localparam int          TO = 255;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cpu_idle = 1'b0;
  logic cpu_halt, poweroff;
  pwr_seq_if bus();

  pwr_seq dut (.clk(clk), .reset(reset), .bus(bus), .cpu_idle(cpu_idle),
               .cpu_halt(cpu_halt), .poweroff(poweroff));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [31:0] last_rdata;

  // Reference model: remembers the cycle each phase began; phase is derived
  // from which timestamps exist.
  int cyc = 0, req_at = -1, cnt_at = -1, off_at = -1;
  bit m_tflag = 1'b0;
  logic [15:0] m_delay = 16'd16;

  function automatic logic [1:0] m_state();
    if (req_at < 0) return 2'd0;
    if (cnt_at < 0) return 2'd1;
    if (off_at < 0) return 2'd2;
    return 2'd3;
  endfunction

  task automatic model_edge(input bit r, v, input logic [31:0] a, d,
                            input logic [3:0] s, input bit idle);
    if (r) begin
      req_at = -1; cnt_at = -1; off_at = -1; m_tflag = 1'b0; m_delay = 16'd16;
    end else begin
      case (m_state())
        2'd0: if (v && s != 4'd0) begin
          if (a == D && s[0]) m_delay[7:0]  = d[7:0];
          if (a == D && s[1]) m_delay[15:8] = d[15:8];
          if (a == A && s[0] && d[7:0] != 8'd0) req_at = cyc + 1;
        end
        2'd1: if (idle) cnt_at = cyc + 1;
              else if (cyc - req_at == TO) begin m_tflag = 1'b1; cnt_at = cyc + 1; end
        2'd2: if (cyc - cnt_at == int'(m_delay)) off_at = cyc + 1;
        default: ;
      endcase
    end
    cyc++;
  endtask

  task automatic check(input string nm, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input bit r, v, input logic [31:0] a, d,
                      input logic [3:0] s, input bit idle);
    logic [31:0] exp_rd;
    bit exp_sel;
    @(negedge clk);
    reset = r; bus.mem_valid = v; bus.mem_addr = a; bus.mem_wdata = d;
    bus.mem_wstrb = s; cpu_idle = idle;
    #1;
    exp_sel = v && (a == A || a == D);
    exp_rd  = !exp_sel ? 32'd0 : (a == A) ? {29'd0, m_tflag, m_state()} : {16'd0, m_delay};
    check("sel", 32'(bus.pwr_sel), 32'(exp_sel));
    check("ready", 32'(bus.pwr_ready), 32'd1);
    check("rdata", bus.pwr_rdata, exp_rd);
    last_rdata = bus.pwr_rdata;
    @(posedge clk);
    model_edge(r, v, a, d, s, idle);
    #1;
    check("cpu_halt", 32'(cpu_halt), 32'(m_state() != 2'd0));
    check("poweroff", 32'(poweroff), 32'(m_state() == 2'd3));
  endtask

  typedef struct {
    bit rst; bit vld; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; bit idle;
    bit chk_rd; logic [31:0] exp_rd; bit exp_halt; bit exp_off;
  } vec_t;
  vec_t tbl[15];

  initial begin
    int hc;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;

    // reset values, ignored writes, then delay=3 minimum-latency shutdown
    tbl[0]  = '{1, 0, 0, 0,            4'd0,    0, 0, 0,     0, 0};
    tbl[1]  = '{0, 1, A, 0,            4'd0,    0, 1, 0,     0, 0};
    tbl[2]  = '{0, 1, D, 0,            4'd0,    0, 1, 32'h10, 0, 0};
    tbl[3]  = '{0, 1, D, 3,            4'b0001, 0, 0, 0,     0, 0};
    tbl[4]  = '{0, 1, A, 0,            4'b0001, 1, 0, 0,     0, 0};
    tbl[5]  = '{0, 1, A, 32'hff,       4'b0010, 1, 0, 0,     0, 0};
    tbl[6]  = '{0, 1, O, 0,            4'd0,    1, 1, 0,     0, 0};
    tbl[7]  = '{0, 1, D, 0,            4'd0,    1, 1, 3,     0, 0};
    tbl[8]  = '{0, 1, A, 1,            4'b0001, 1, 0, 0,     1, 0};
    tbl[9]  = '{0, 1, A, 0,            4'd0,    1, 1, 1,     1, 0};
    tbl[10] = '{0, 1, D, 32'h1234,     4'b0011, 1, 0, 0,     1, 0};
    tbl[11] = '{0, 1, D, 0,            4'd0,    1, 1, 3,     1, 0};
    tbl[12] = '{0, 1, A, 0,            4'd0,    1, 1, 2,     1, 0};
    tbl[13] = '{0, 0, 0, 0,            4'd0,    1, 0, 0,     1, 1};
    tbl[14] = '{0, 1, A, 0,            4'd0,    1, 1, 3,     1, 1};
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].idle);
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_rd", i), last_rdata, tbl[i].exp_rd);
      check($sformatf("tbl%0d_halt", i), 32'(cpu_halt), 32'(tbl[i].exp_halt));
      check($sformatf("tbl%0d_off", i), 32'(poweroff), 32'(tbl[i].exp_off));
    end

    // reset in OFF
    step(1, 0, 0, 0, 0, 0);
    check("off_rst_halt", 32'(cpu_halt), 32'd0);
    check("off_rst_poff", 32'(poweroff), 32'd0);
    step(0, 1, A, 0, 0, 0); check("off_rst_ctrl", last_rdata, 32'd0);
    step(0, 1, D, 0, 0, 0); check("off_rst_dly", last_rdata, 32'h10);

    // timeout path, delay=0, DELAY write blocked while halted
    step(0, 1, D, 0, 4'b0011, 0);
    step(0, 1, A, 1, 4'b0001, 0);
    step(0, 1, D, 32'h1234, 4'b0011, 0);
    hc = 1;
    for (int i = 0; i < 400; i++) begin
      step(0, 1, A, 0, 0, 0);
      if (last_rdata[1:0] != 2'd1) break;
      hc++;
    end
    check("to_halt_cycles", 32'(hc), 32'd256);
    check("to_ctrl_count", last_rdata, 32'h6);
    check("to_poff", 32'(poweroff), 32'd1);
    step(0, 1, A, 0, 0, 0); check("to_ctrl_off", last_rdata, 32'h7);
    step(0, 1, D, 0, 0, 0); check("to_dly_kept", last_rdata, 32'h0);

    // idle arrives on the cnt==0 HALT cycle: no timeout flag
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, A, 1, 4'b0001, 0);
    for (int i = 0; i < 255; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 1, A, 0, 0, 1); check("edge_ctrl_halt", last_rdata, 32'h1);
    step(0, 1, A, 0, 0, 0); check("edge_ctrl_count", last_rdata, 32'h2);

    // reset in COUNT
    step(1, 0, 0, 0, 0, 0);
    check("cnt_rst_halt", 32'(cpu_halt), 32'd0);
    check("cnt_rst_poff", 32'(poweroff), 32'd0);
    step(0, 1, A, 0, 0, 0); check("cnt_rst_ctrl", last_rdata, 32'd0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] a, d;
      int k;
      k = $urandom_range(0, 9);
      a = (k < 4) ? A : (k < 8) ? D : $urandom;
      d = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) d[15:8] = 8'h01;
      if ($urandom_range(0, 7) == 0) d[7:0] = 8'h00;
      d[31:16] = 16'($urandom);
      step($urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0, a, d,
           ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
